// File: rtl/bmc_soft_pipe.sv
// Two-stage branch metric unit for the Viterbi decoder with valid/ready flow control.
// Optional BMC_NORM_EN subtracts the per-symbol minimum metric from every output metric.

module bmc_lane #(
  parameter int N      = 2,
  parameter int SOFT_W = 3,
  parameter int BM_W   = 4,
  parameter int CW     = 0
) (
  input  logic [N*SOFT_W-1:0] data,
  input  logic [N-1:0]        erase,
  output logic [BM_W-1:0]     bm
);
  localparam logic [N-1:0]      CWB  = N'(CW);
  localparam logic [SOFT_W-1:0] MAXS = {SOFT_W{1'b1}};

  logic [SOFT_W-1:0] s;

  always_comb begin
    bm = '0;
    s  = '0;
    for (int j = 0; j < N; j++) begin
      s = data[SOFT_W*j +: SOFT_W];
      // An expected 1 is closest to an all-ones sample, so that case uses the mirrored distance.
      if (!erase[j]) bm = bm + BM_W'(CWB[j] ? MAXS - s : s);
    end
  end
endmodule

module bmc_soft_pipe #(
  parameter int N      = 2,
  parameter int SOFT_W = 3,
  parameter int CNT_W  = 16,
  localparam int BM_W  = SOFT_W + $clog2(N),
  localparam int NC    = 1 << N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*SOFT_W-1:0]  in_data,
  input  logic [N-1:0]         in_erase,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NC*BM_W-1:0]   out_bm,
  output logic                 out_last,
  output logic [CNT_W-1:0]     sym_cnt
);
  logic [2:1]                 vld_pipe;
  logic [N*SOFT_W-1:0]        s1_data;
  logic [N-1:0]               s1_erase;
  logic                       s1_last;
  logic [NC-1:0][BM_W-1:0]    bm_raw;
  logic [NC-1:0][BM_W-1:0]    bm_nxt;
  logic                       s1_adv, s2_adv;

  assign s2_adv    = !vld_pipe[2] || out_ready;
  assign s1_adv    = !vld_pipe[1] || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = vld_pipe[2];

  for (genvar c = 0; c < NC; c++) begin : g_lane
    bmc_lane #(.N(N), .SOFT_W(SOFT_W), .BM_W(BM_W), .CW(c)) u_lane (
      .data  (s1_data),
      .erase (s1_erase),
      .bm    (bm_raw[c])
    );
  end

`ifdef BMC_NORM_EN
  logic [BM_W-1:0] bm_min;

  always_comb begin
    bm_min = bm_raw[0];
    for (int c = 1; c < NC; c++)
      if (bm_raw[c] < bm_min) bm_min = bm_raw[c];
    bm_nxt = '0;
    for (int c = 0; c < NC; c++)
      bm_nxt[c] = bm_raw[c] - bm_min;
  end
`else
  assign bm_nxt = bm_raw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_data  <= '0;
      s1_erase <= '0;
      s1_last  <= 1'b0;
      out_bm   <= '0;
      out_last <= 1'b0;
      sym_cnt  <= '0;
    end else begin
      // S2 moves first in intent: when it advances, S1 may refill in the same edge.
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          out_bm   <= bm_nxt;
          out_last <= s1_last;
        end
      end
      if (s1_adv) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) begin
          s1_data  <= in_data;
          s1_erase <= in_erase;
          s1_last  <= in_last;
        end
      end
      if (in_valid && in_ready) sym_cnt <= sym_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Directed bench for bmc_soft_pipe: default build (N=2, SOFT_W=3), a hard-decision
// instance (SOFT_W=1) and a narrow-counter instance (CNT_W=2).
module tb_bmc_soft_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // main instance
  logic        in_valid = 0, in_last = 0, out_ready = 1;
  logic [5:0]  in_data = '0;
  logic [1:0]  in_erase = '0;
  logic        in_ready, out_valid, out_last;
  logic [15:0] out_bm, sym_cnt;

  bmc_soft_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_erase(in_erase), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_bm(out_bm), .out_last(out_last), .sym_cnt(sym_cnt)
  );

  // hard-decision instance
  logic        h_in_valid = 0, h_in_ready, h_out_valid, h_out_last;
  logic [1:0]  h_in_data = '0;
  logic [7:0]  h_out_bm;
  logic [15:0] h_sym_cnt;

  bmc_soft_pipe #(.N(2), .SOFT_W(1), .CNT_W(16)) dut_h (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .in_data(h_in_data),
    .in_erase(2'b00), .in_last(1'b0), .out_valid(h_out_valid), .out_ready(1'b1),
    .out_bm(h_out_bm), .out_last(h_out_last), .sym_cnt(h_sym_cnt)
  );

  // narrow counter instance
  logic        c_in_valid = 0, c_in_ready, c_out_valid, c_out_last;
  logic [15:0] c_out_bm;
  logic [1:0]  c_sym_cnt;

  bmc_soft_pipe #(.N(2), .SOFT_W(3), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(6'o70),
    .in_erase(2'b00), .in_last(1'b0), .out_valid(c_out_valid), .out_ready(1'b1),
    .out_bm(c_out_bm), .out_last(c_out_last), .sym_cnt(c_sym_cnt)
  );

  // Reference metric for the default build, out packed c3..c0.
  function automatic logic [15:0] model(logic [5:0] d, logic [1:0] e);
    int m[4];
    int s, mn;
    logic [15:0] r;
    for (int c = 0; c < 4; c++) begin
      m[c] = 0;
      for (int j = 0; j < 2; j++) begin
        s = int'(d[3*j +: 3]);
        if (!e[j]) m[c] += ((c >> j) & 1) ? 7 - s : s;
      end
    end
`ifdef BMC_NORM_EN
    mn = m[0];
    for (int c = 1; c < 4; c++) if (m[c] < mn) mn = m[c];
    for (int c = 0; c < 4; c++) m[c] -= mn;
`else
    mn = 0;
`endif
    r = '0;
    for (int c = 0; c < 4; c++) r[4*c +: 4] = 4'(m[c]);
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 0; h_in_valid = 0; c_in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Present one symbol on an idle pipeline; returns with it accepted (one edge later).
  task automatic send(input logic [5:0] d, input logic [1:0] e, input logic l);
    in_valid = 1; in_data = d; in_erase = e; in_last = l;
    @(posedge clk); #1;
    in_valid = 0; in_data = 6'h2a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_bm !== 16'h0) begin failures++; $display("FAIL reset_out_bm got=%h want=0000", out_bm); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    checks++; if (sym_cnt !== 16'd0) begin failures++; $display("FAIL reset_sym_cnt got=%0d want=0", sym_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    send({3'd7, 3'd0}, 2'b00, 1'b0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b want=0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b want=1", out_valid); end
    checks++; if (out_bm !== {4'd7, 4'd0, 4'd14, 4'd7}) begin failures++; $display("FAIL basic_bm got=%h want=70e7", out_bm); end
    checks++; if (sym_cnt !== 16'd1) begin failures++; $display("FAIL basic_sym_cnt got=%0d want=1", sym_cnt); end
  endtask

  task automatic test_metrics();
    logic [15:0] want;
    send({3'd4, 3'd3}, 2'b00, 1'b1);
    @(posedge clk); #1;
`ifdef BMC_NORM_EN
    want = {4'd1, 4'd0, 4'd2, 4'd1};
`else
    want = {4'd7, 4'd6, 4'd8, 4'd7};
`endif
    checks++; if (out_bm !== want) begin failures++; $display("FAIL mixed_bm got=%h want=%h", out_bm, want); end
    checks++; if (out_last !== 1'b1) begin failures++; $display("FAIL mixed_last got=%b want=1", out_last); end
    send({3'd7, 3'd0}, 2'b10, 1'b0);
    @(posedge clk); #1;
    checks++; if (out_bm !== {4'd7, 4'd0, 4'd7, 4'd0}) begin failures++; $display("FAIL erase1_bm got=%h want=7070", out_bm); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL erase1_last got=%b want=0", out_last); end
    send({3'd5, 3'd2}, 2'b11, 1'b0);
    @(posedge clk); #1;
    checks++; if (out_bm !== 16'h0000) begin failures++; $display("FAIL erase_all_bm got=%h want=0000", out_bm); end
    checks++; if (sym_cnt !== 16'd4) begin failures++; $display("FAIL metrics_sym_cnt got=%0d want=4", sym_cnt); end
  endtask

  task automatic test_hard();
    h_in_valid = 1; h_in_data = 2'b10;
    @(posedge clk); #1;
    h_in_valid = 0;
    @(posedge clk); #1;
    checks++; if (h_out_valid !== 1'b1) begin failures++; $display("FAIL hard_valid got=%b want=1", h_out_valid); end
    checks++; if (h_out_bm !== {2'd1, 2'd0, 2'd2, 2'd1}) begin failures++; $display("FAIL hard_bm got=%b want=01001001", h_out_bm); end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  d[8] = '{6'o70, 6'o43, 6'o16, 6'o22, 6'o51, 6'o07, 6'o34, 6'o65};
    logic [1:0]  e[8] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00};
    logic [31:0] rdy = 32'b0110_1001_1100_0101_1011_0011_1000_1110;
    logic [15:0] exp_q[$];
    logic        lst_q[$];
    logic [15:0] held_bm, want;
    logic        held, want_l;
    int sent = 0, got = 0, occ = 0, cyc = 0;
    do_reset();
    held = 0; held_bm = '0;
    while (got < 8 && cyc < 200) begin
      in_valid  = (sent < 8);
      in_data   = d[sent % 8];
      in_erase  = e[sent % 8];
      in_last   = (sent == 7);
      out_ready = rdy[cyc % 32];
      @(negedge clk);
      checks++;
      if (in_ready !== !(occ == 2 && !out_ready)) begin
        failures++; $display("FAIL stream_in_ready cyc=%0d got=%b occ=%0d out_ready=%b", cyc, in_ready, occ, out_ready);
      end
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_bm !== held_bm) begin
          failures++; $display("FAIL stream_stall_hold cyc=%0d got=%b/%h want=1/%h", cyc, out_valid, out_bm, held_bm);
        end
      end
      held = out_valid && !out_ready; held_bm = out_bm;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL stream_extra got=%h want=none", out_bm);
        end else begin
          want = exp_q.pop_front(); want_l = lst_q.pop_front();
          if (out_bm !== want || out_last !== want_l) begin
            failures++; $display("FAIL stream_out idx=%0d got=%h/%b want=%h/%b", got, out_bm, out_last, want, want_l);
          end
        end
        got++; occ--;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data, in_erase)); lst_q.push_back(in_last);
        sent++; occ++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 0; out_ready = 1;
    checks++; if (got != 8 || sent != 8) begin failures++; $display("FAIL stream_count got=%0d sent=%0d want=8/8", got, sent); end
    checks++; if (sym_cnt !== 16'd8) begin failures++; $display("FAIL stream_sym_cnt got=%0d want=8", sym_cnt); end
  endtask

  task automatic test_reset_flight();
    int seen = 0;
    do_reset();
    out_ready = 0;
    in_valid = 1; in_data = 6'o70; in_erase = 2'b00; in_last = 0;
    @(posedge clk); #1;
    in_data = 6'o43;
    @(posedge clk); #1;
    in_valid = 0;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flight_out_valid got=%b want=0", out_valid); end
    checks++; if (sym_cnt !== 16'd0) begin failures++; $display("FAIL flight_sym_cnt got=%0d want=0", sym_cnt); end
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL flight_stale got=%0d outputs want=0", seen); end
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    c_in_valid = 1;
    repeat (5) begin @(posedge clk); #1; end
    c_in_valid = 0;
    checks++; if (c_sym_cnt !== 2'd1) begin failures++; $display("FAIL cnt_wrap got=%0d want=1", c_sym_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_metrics();
    test_hard();
    test_back_to_back();
    test_reset_flight();
    test_cnt_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
